rv32_fetch: RTL
===============

RV32_FETCH -- requirements
Module: rv32_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (ADDI x0,x0,0), is the bubble instruction.
REQ-003 clk  input  1  Single clock; all state updates on the rising edge.
REQ-004 rst  input  1  Synchronous, active-high reset.
REQ-005 imem_req  output  1  Instruction-memory request valid.
REQ-006 imem_addr  output  32  Fetch address; word-aligned.
REQ-007 imem_ack  input  1  Response valid; may arrive in the request cycle or any later cycle.
REQ-008 imem_rdata  input  32  Instruction word; valid only when imem_ack=1.
REQ-009 stall  input  1  Hazard unit: hold the IF/ID register contents.
REQ-010 redirect  input  1  Taken branch/jump from EX: flush and refetch.
REQ-011 redirect_pc  input  32  Target address when redirect=1.
REQ-012 if_id_ir  output  32  Registered instruction feeding decode/immediate generation.
REQ-013 if_id_pc  output  32  PC of if_id_ir.
REQ-014 if_id_pc4  output  32  if_id_pc+4.
REQ-015 if_id_valid  output  1  if_id_ir is a real instruction; when 0, if_id_ir = NOP_INSTR.

Function
REQ-016 FSM states: IDLE, FETCH, HOLD, DRAIN.
REQ-017 IDLE: imem_req=0; always moves to FETCH the next cycle.
REQ-018 FETCH: imem_req=1 and imem_addr=PC; both stay stable until imem_ack.
REQ-019 FETCH, ack, no stall, no redirect: IF/ID loads {imem_rdata, PC, PC+4} with valid=1; PC<=PC+4; stays in FETCH, so back-to-back zero-wait fetches give one instruction per cycle.
REQ-020 FETCH, ack, stall=1: the word and PC go into a one-entry buffer; IF/ID holds; PC<=PC+4; state becomes HOLD.
REQ-021 HOLD: imem_req=0; when stall falls, the buffer moves into IF/ID (valid=1) and the state becomes FETCH.
REQ-022 stall=1 with no new instruction: IF/ID holds unchanged.
REQ-023 stall=0 with no new instruction: IF/ID loads a bubble (valid=0, ir=NOP_INSTR; pc/pc4 hold).
REQ-024 redirect takes priority over stall and ack. The same edge does all of the following:
  - IF/ID is flushed to a bubble.
  - The buffer is cleared.
  - PC<=redirect_pc with bits [1:0] forced to 0.
REQ-025 Redirect in FETCH without ack in the same cycle: state becomes DRAIN.
REQ-026 Redirect with ack in the same cycle, or in HOLD or IDLE: the returning word is discarded and the state becomes FETCH.
REQ-027 DRAIN: imem_req stays 1 and imem_addr stays at the old address until ack. The acked word is discarded and the state becomes FETCH with the new PC.
REQ-028 Redirect during DRAIN: PC updates to the newest target and the state stays in DRAIN.
REQ-029 PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0.
REQ-030 The unit issues no new request while an instruction is buffered, so at most one instruction is in flight.

Reset
REQ-031 rst=1 at an edge sets the following, independent of any other input:
  - state=IDLE and PC=RESET_PC
  - imem_req=0 and imem_addr=RESET_PC
  - if_id_valid=0 and if_id_ir=NOP_INSTR
  - if_id_pc=0 and if_id_pc4=0
  - buffer empty
REQ-032 Reset during FETCH or DRAIN abandons the outstanding request; any ack in the following IDLE cycle is ignored.

Structure
REQ-033 NOP_INSTR, the state encodings and the opcode defines go in the shared defines file.
REQ-034 The one-entry buffer is a sub-module, rv32_fetch_buf (load, unload, clear, data/pc, full).
REQ-035 The IF/ID register lives inside rv32_fetch; decode consumes if_id_ir directly.

Verification
REQ-036 Release rst, zero-wait ack every cycle, memory returns addr|1:
  - first imem_req with addr 0 appears in cycle 1 after reset;
  - if_id_pc runs 0,4,8 on consecutive cycles with valid=1.
REQ-037 Ack latency 3:
  - imem_addr is held 3 cycles;
  - if_id_valid=0 bubbles are inserted between instructions.
REQ-038 stall=1 for 4 cycles while the word at PC 8 is acked:
  - IF/ID holds PC 4;
  - PC 8 appears in the cycle after stall falls;
  - no instruction is lost or duplicated.
REQ-039 redirect to 32'h100 while the ack for PC 12 is pending:
  - the old word is discarded (DRAIN);
  - the next valid if_id_pc is 32'h100;
  - IF/ID is a bubble in the redirect cycle.
REQ-040 redirect and stall together with redirect_pc=32'h203: IF/ID is flushed and the next fetch address is 32'h200.
REQ-041 rst asserted mid-DRAIN with an ack the next cycle: the ack is ignored and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/rv32_fetch_pkg.sv
// Shared definitions for the RV32 instruction-fetch unit: widths, opcodes,
// bubble instruction, FSM encoding and IF/ID payload types.
package rv32_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [2:0] F3_ADDI    = 3'b000;

  // ADDI x0,x0,0
  localparam logic [ILEN-1:0] NOP_INSTR_DEF = {12'h000, 5'd0, F3_ADDI, 5'd0, OPC_OP_IMM};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [ILEN-1:0] ir;
    logic [XLEN-1:0] pc;
  } fetch_word_t;

  typedef struct packed {
    logic            valid;
    logic [ILEN-1:0] ir;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } if_id_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/rv32_fetch_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
interface rv32_fetch_if;
  import rv32_fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [ILEN-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/rv32_fetch_buf.sv
// One-entry skid buffer holding a fetched word while decode is stalled.
module rv32_fetch_buf
  import rv32_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  fetch_word_t wr_data,
  output fetch_word_t rd_data,
  output logic        full
);

  fetch_word_t data_q, data_d;
  logic        full_q, full_d;

  // clear wins over load so a redirect never leaves a stale word behind
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (clear) begin
      full_d = 1'b0;
    end else if (load) begin
      data_d = wr_data;
      full_d = 1'b1;
    end else if (unload) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign rd_data = data_q;
  assign full    = full_q;

endmodule

// File: rtl/rv32_fetch.sv
// RV32 instruction-fetch stage: drives the imem bus and the IF/ID register,
// handling stalls (via a one-entry buffer) and redirects (with drain).
module rv32_fetch
  import rv32_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [ILEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic             clk,
  input  logic             rst,
  rv32_fetch_if.master     imem,
  input  logic             stall,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic [ILEN-1:0]  if_id_ir,
  output logic [XLEN-1:0]  if_id_pc,
  output logic [XLEN-1:0]  if_id_pc4,
  output logic             if_id_valid
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;
  if_id_t          ifid_q, ifid_d;

  logic        buf_load, buf_unload, buf_clear, buf_full;
  fetch_word_t buf_wr, buf_rd;

  assign buf_wr = '{ir: imem.imem_rdata, pc: pc_q};

  rv32_fetch_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .load    (buf_load),
    .unload  (buf_unload),
    .clear   (buf_clear),
    .wr_data (buf_wr),
    .rd_data (buf_rd),
    .full    (buf_full)
  );

  // Next-state, PC and IF/ID update; redirect overrides everything else
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ifid_d     = ifid_q;
    buf_load   = 1'b0;
    buf_unload = 1'b0;
    buf_clear  = 1'b0;

    // no new instruction: hold under stall, otherwise bubble
    if (!stall) begin
      ifid_d.valid = 1'b0;
      ifid_d.ir    = NOP_INSTR;
    end

    if (redirect) begin
      ifid_d.valid = 1'b0;
      ifid_d.ir    = NOP_INSTR;
      buf_clear    = 1'b1;
      pc_d         = align_word(redirect_pc);
      if ((state_q == ST_FETCH || state_q == ST_DRAIN) && !imem.imem_ack) begin
        state_d = ST_DRAIN;
      end else begin
        state_d = ST_FETCH;
      end
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_FETCH;
        ST_FETCH: begin
          if (imem.imem_ack) begin
            pc_d = pc_q + XLEN'(4);
            if (stall) begin
              buf_load = 1'b1;
              state_d  = ST_HOLD;
            end else begin
              ifid_d = '{valid: 1'b1, ir: imem.imem_rdata, pc: pc_q, pc4: pc_q + XLEN'(4)};
            end
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            state_d = ST_FETCH;
            if (buf_full) begin
              buf_unload = 1'b1;
              ifid_d     = '{valid: 1'b1, ir: buf_rd.ir, pc: buf_rd.pc, pc4: buf_rd.pc + XLEN'(4)};
            end
          end
        end
        ST_DRAIN: begin
          if (imem.imem_ack) state_d = ST_FETCH;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // DRAIN keeps presenting the abandoned address until it is acked
    req_d  = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
    addr_d = (state_d == ST_DRAIN) ? addr_q : pc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      ifid_q  <= '{valid: 1'b0, ir: NOP_INSTR, pc: '0, pc4: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      ifid_q  <= ifid_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign if_id_valid    = ifid_q.valid;
  assign if_id_ir       = ifid_q.ir;
  assign if_id_pc       = ifid_q.pc;
  assign if_id_pc4      = ifid_q.pc4;

endmodule
